// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master memory arbiter: FSM states and master identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam logic MASTER_I = 1'b0;
    localparam logic MASTER_D = 1'b1;

endpackage

// File: rtl/mem_arb_outst_cnt.sv
// Outstanding-read counter: up on accepted read, down on returned beat, never goes below zero.
module mem_arb_outst_cnt #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_max,
    output logic             o_next_is_zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             dec_eff;

    // A return beat with nothing outstanding is a stray and must not wrap the count.
    always_comb begin
        dec_eff = i_dec & (count_q != '0);
        count_d = count_q;
        if (i_inc && !dec_eff) begin
            count_d = count_q + CNT_W'(1);
        end else if (!i_inc && dec_eff) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count        = count_q;
    assign o_at_max       = (count_q == CNT_W'(MAX_OUTST));
    assign o_next_is_zero = (count_d == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the icache or dcache exclusive use of the memory port until
// the owner goes quiet and every read it issued has returned.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_imem_addr,
    input  logic        i_imem_ren,
    input  logic        i_imem_wen,
    input  logic [31:0] i_imem_wdata,
    output logic        o_imem_ready,
    output logic [31:0] o_imem_rdata,
    output logic        o_imem_valid,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_ready,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             last_gnt_q;
    logic             last_gnt_d;

    logic             own_ren;
    logic             own_wen;
    logic [31:0]      own_addr;
    logic [31:0]      own_wdata;
    logic             own_ready;
    logic             beat_ok;
    logic             i_req;
    logic             d_req;

    logic [CNT_W-1:0] outst;
    logic             at_max;
    logic             next_is_zero;

    assign i_req = i_imem_ren | i_imem_wen;
    assign d_req = i_dmem_ren | i_dmem_wen;

    mem_arb_outst_cnt #(
        .MAX_OUTST(MAX_OUTST),
        .CNT_W    (CNT_W)
    ) u_cnt (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_inc         (o_mem_ren & i_mem_ready),
        .i_dec         (i_mem_valid),
        .o_count       (outst),
        .o_at_max      (at_max),
        .o_next_is_zero(next_is_zero)
    );

    // Forward the owner's request; a simultaneous ren+wen is treated as a write.
    always_comb begin
        own_ren   = 1'b0;
        own_wen   = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        case (state_q)
            GNT_I: begin
                own_ren   = i_imem_ren;
                own_wen   = i_imem_wen;
                own_addr  = i_imem_addr;
                own_wdata = i_imem_wdata;
            end
            GNT_D: begin
                own_ren   = i_dmem_ren;
                own_wen   = i_dmem_wen;
                own_addr  = i_dmem_addr;
                own_wdata = i_dmem_wdata;
            end
            default: ;
        endcase

        own_ready   = (state_q != IDLE) & i_mem_ready & ~(own_ren & at_max);
        beat_ok     = (state_q != IDLE) & i_mem_valid & (outst != '0);

        o_mem_addr  = own_addr;
        o_mem_wdata = own_wdata;
        o_mem_wen   = own_wen;
        o_mem_ren   = own_ren & ~own_wen & ~at_max;

        o_imem_ready = (state_q == GNT_I) & own_ready;
        o_dmem_ready = (state_q == GNT_D) & own_ready;
        o_imem_valid = (state_q == GNT_I) & beat_ok;
        o_dmem_valid = (state_q == GNT_D) & beat_ok;
        o_imem_rdata = (state_q == GNT_I) ? i_mem_rdata : '0;
        o_dmem_rdata = (state_q == GNT_D) ? i_mem_rdata : '0;
    end

    // On a tie the master that did not hold the last grant wins.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_gnt_q == MASTER_I) ? GNT_D : GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end else if (i_req) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (!own_ren && !own_wen && next_is_zero) begin
                    state_d    = IDLE;
                    last_gnt_d = (state_q == GNT_D) ? MASTER_D : MASTER_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            last_gnt_q <= MASTER_I;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory/cache models drive the ports, a scoreboard checks returned
// read data, an arbitration table checks round-robin order, and directed sequences cover stalls.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} req_t;
    typedef struct {logic m; logic [31:0] data;} exp_t;
    typedef struct {logic [31:0] addr; int due;} pend_t;
    typedef struct {logic [31:0] addr; logic [31:0] data; logic [1:0] st; int busy;} wlog_t;
    typedef struct {logic iReq; logic dReq; int expN; logic firstD;} arb_vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_imem_addr = '0, i_imem_wdata = '0, i_dmem_addr = '0, i_dmem_wdata = '0;
    logic        i_imem_ren = 1'b0, i_imem_wen = 1'b0, i_dmem_ren = 1'b0, i_dmem_wen = 1'b0;
    logic        i_mem_ready = 1'b1, i_mem_valid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_imem_ready, o_imem_valid, o_dmem_ready, o_dmem_valid;
    logic        o_mem_ren, o_mem_wen;
    logic [31:0] o_imem_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata;

    req_t    iq[$];
    req_t    dq[$];
    exp_t    sb[$];
    pend_t   pipe[$];
    wlog_t   wlog[$];
    int      cyc = 0;
    int      retAllow = 1000000;
    int      vecCount = 0;
    int      missCount = 0;
    int      iBeats = 0;
    int      dBeats = 0;
    int      peak = 0;
    logic    popI = 1'b0;
    logic    popD = 1'b0;
    arb_vec_t arbTable[6];

    mem_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_imem_addr(i_imem_addr), .i_imem_ren(i_imem_ren), .i_imem_wen(i_imem_wen),
        .i_imem_wdata(i_imem_wdata), .o_imem_ready(o_imem_ready), .o_imem_rdata(o_imem_rdata),
        .o_imem_valid(o_imem_valid),
        .i_dmem_addr(i_dmem_addr), .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen),
        .i_dmem_wdata(i_dmem_wdata), .o_dmem_ready(o_dmem_ready), .o_dmem_rdata(o_dmem_rdata),
        .o_dmem_valid(o_dmem_valid),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .i_mem_valid(i_mem_valid)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memData(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic driveMasters();
        i_imem_ren = (iq.size() > 0) && !iq[0].wr;
        i_imem_wen = (iq.size() > 0) && iq[0].wr;
        i_imem_addr = (iq.size() > 0) ? iq[0].addr : '0;
        i_imem_wdata = (iq.size() > 0) ? iq[0].data : '0;
        i_dmem_ren = (dq.size() > 0) && !dq[0].wr;
        i_dmem_wen = (dq.size() > 0) && dq[0].wr;
        i_dmem_addr = (dq.size() > 0) ? dq[0].addr : '0;
        i_dmem_wdata = (dq.size() > 0) ? dq[0].data : '0;
    endtask

    // Observe the settled cycle at the falling edge, then advance one clock and drive new inputs.
    task automatic applyStimulus();
        exp_t e;
        wlog_t w;
        @(negedge i_clk);
        popI = o_imem_ready & (i_imem_ren | i_imem_wen);
        popD = o_dmem_ready & (i_dmem_ren | i_dmem_wen);
        if (o_imem_ready && i_imem_ren && !i_imem_wen) sb.push_back('{MASTER_I, memData(i_imem_addr)});
        if (o_dmem_ready && i_dmem_ren && !i_dmem_wen) sb.push_back('{MASTER_D, memData(i_dmem_addr)});
        if (o_mem_ren && i_mem_ready) pipe.push_back('{o_mem_addr, cyc + 2});
        if (o_mem_wen && i_mem_ready) begin
            w = '{o_mem_addr, o_mem_wdata, dut.state_q, sb.size()};
            wlog.push_back(w);
        end
        if (int'(dut.u_cnt.count_q) > peak) peak = int'(dut.u_cnt.count_q);
        if (o_imem_valid && o_dmem_valid) checkOutput("dual_valid", 32'd1, 32'd0);
        else if (o_imem_valid || o_dmem_valid) begin
            if (sb.size() == 0) checkOutput("stray_valid", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                checkOutput("owner", {31'd0, o_dmem_valid}, {31'd0, e.m});
                checkOutput("rdata", o_dmem_valid ? o_dmem_rdata : o_imem_rdata, e.data);
                if (o_dmem_valid) dBeats++; else iBeats++;
            end
        end
        @(posedge i_clk);
        #1;
        cyc++;
        if (popI) void'(iq.pop_front());
        if (popD) void'(dq.pop_front());
        driveMasters();
        if (pipe.size() > 0 && pipe[0].due <= cyc && retAllow > 0) begin
            i_mem_valid = 1'b1;
            i_mem_rdata = memData(pipe[0].addr);
            void'(pipe.pop_front());
            retAllow--;
        end else begin
            i_mem_valid = 1'b0;
            i_mem_rdata = '0;
        end
        #2;
    endtask

    task automatic waitIdle(input string name, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            if (iq.size() == 0 && dq.size() == 0 && sb.size() == 0 && pipe.size() == 0 &&
                dut.state_q == IDLE) break;
            applyStimulus();
        end
        if (k == bound) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        arbTable[0] = '{1'b1, 1'b1, 2, 1'b1};
        arbTable[1] = '{1'b1, 1'b1, 2, 1'b1};
        arbTable[2] = '{1'b0, 1'b1, 1, 1'b1};
        arbTable[3] = '{1'b1, 1'b1, 2, 1'b0};
        arbTable[4] = '{1'b1, 1'b0, 1, 1'b0};
        arbTable[5] = '{1'b1, 1'b1, 2, 1'b1};

        repeat (3) applyStimulus();
        i_rst = 1'b0;
        #1;
        checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("rst_outst", 32'(dut.u_cnt.count_q), 32'd0);
        checkOutput("rst_mem_req", {30'd0, o_mem_ren, o_mem_wen}, 32'd0);
        checkOutput("rst_mem_addr", o_mem_addr, 32'd0);
        checkOutput("rst_ready", {30'd0, o_imem_ready, o_dmem_ready}, 32'd0);
        checkOutput("rst_valid", {30'd0, o_imem_valid, o_dmem_valid}, 32'd0);

        // Arbitration order: round robin starting with D after reset.
        for (int r = 0; r < 6; r++) begin
            logic [31:0] aI, aD, first, second;
            aI = 32'h1000 + 32'(r * 16);
            aD = 32'h2000 + 32'(r * 16);
            wlog.delete();
            if (arbTable[r].iReq) iq.push_back('{1'b1, aI, ~aI});
            if (arbTable[r].dReq) dq.push_back('{1'b1, aD, ~aD});
            driveMasters();
            waitIdle("arb", 40);
            first  = arbTable[r].firstD ? aD : aI;
            second = arbTable[r].firstD ? aI : aD;
            checkOutput("arb_nwrites", 32'(wlog.size()), 32'(arbTable[r].expN));
            if (wlog.size() >= 1) begin
                checkOutput("arb_first", wlog[0].addr, first);
                checkOutput("arb_wdata", wlog[0].data, ~first);
                checkOutput("arb_first_st", 32'(wlog[0].st),
                            arbTable[r].firstD ? 32'(GNT_D) : 32'(GNT_I));
            end
            if (arbTable[r].expN == 2 && wlog.size() >= 2) checkOutput("arb_second", wlog[1].addr, second);
        end

        // Dcache line fill of four beats.
        peak = 0;
        dBeats = 0;
        for (int k = 0; k < 4; k++) dq.push_back('{1'b0, 32'h100 + 32'(k * 4), '0});
        driveMasters();
        for (int k = 0; k < 30 && dBeats < 4; k++) applyStimulus();
        checkOutput("fill_beats", 32'(dBeats), 32'd4);
        checkOutput("fill_idle", 32'(dut.state_q), 32'(IDLE));
        checkOutput("fill_peak", 32'(peak), 32'd2);

        // Icache fill in progress; a dcache write must wait for it to drain.
        wlog.delete();
        for (int k = 0; k < 4; k++) iq.push_back('{1'b0, 32'h800 + 32'(k * 4), '0});
        driveMasters();
        repeat (2) applyStimulus();
        dq.push_back('{1'b1, 32'h200, 32'hDEADBEEF});
        driveMasters();
        waitIdle("wr_wait", 60);
        checkOutput("wr_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() >= 1) begin
            checkOutput("wr_addr", wlog[0].addr, 32'h200);
            checkOutput("wr_data", wlog[0].data, 32'hDEADBEEF);
            checkOutput("wr_state", 32'(wlog[0].st), 32'(GNT_D));
            checkOutput("wr_drained", 32'(wlog[0].busy), 32'd0);
        end

        // Memory back-pressure while the icache holds the grant.
        retAllow = 0;
        for (int k = 0; k < 4; k++) iq.push_back('{1'b0, 32'h500 + 32'(k * 4), '0});
        driveMasters();
        for (int k = 0; k < 10 && iq.size() > 2; k++) applyStimulus();
        i_mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("stall_ready", {31'd0, o_imem_ready}, 32'd0);
            checkOutput("stall_state", 32'(dut.state_q), 32'(GNT_I));
            checkOutput("stall_outst", 32'(dut.u_cnt.count_q), 32'd2);
        end
        i_mem_ready = 1'b1;
        retAllow = 1000000;
        waitIdle("stall", 60);

        // Outstanding limit: reads stop at four until a beat returns.
        retAllow = 0;
        for (int k = 0; k < 6; k++) iq.push_back('{1'b0, 32'h300 + 32'(k * 4), '0});
        driveMasters();
        repeat (12) applyStimulus();
        checkOutput("max_outst", 32'(dut.u_cnt.count_q), 32'd4);
        checkOutput("max_ren", {31'd0, o_mem_ren}, 32'd0);
        checkOutput("max_ready", {31'd0, o_imem_ready}, 32'd0);
        checkOutput("max_left", 32'(iq.size()), 32'd2);
        retAllow = 1;
        applyStimulus();
        checkOutput("max_beat", {31'd0, o_imem_valid}, 32'd1);
        checkOutput("max_ren_hold", {31'd0, o_mem_ren}, 32'd0);
        applyStimulus();
        checkOutput("max_ren_resume", {31'd0, o_mem_ren}, 32'd1);
        retAllow = 1000000;
        waitIdle("max", 60);

        // Reset in the middle of a dcache fill; the returns that follow are strays.
        retAllow = 0;
        for (int k = 0; k < 5; k++) dq.push_back('{1'b0, 32'h600 + 32'(k * 4), '0});
        driveMasters();
        for (int k = 0; k < 20 && dq.size() > 2; k++) applyStimulus();
        checkOutput("rst6_pre_outst", 32'(dut.u_cnt.count_q), 32'd3);
        checkOutput("rst6_pre_state", 32'(dut.state_q), 32'(GNT_D));
        dq.delete();
        driveMasters();
        i_rst = 1'b1;
        applyStimulus();
        i_rst = 1'b0;
        sb.delete();
        checkOutput("rst6_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("rst6_outst", 32'(dut.u_cnt.count_q), 32'd0);
        retAllow = 1000000;
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput("rst6_stray", {30'd0, o_imem_valid, o_dmem_valid}, 32'd0);
        end
        checkOutput("rst6_strays_gone", 32'(pipe.size()), 32'd0);
        iBeats = 0;
        iq.push_back('{1'b0, 32'h700, '0});
        driveMasters();
        waitIdle("rst6_after", 30);
        checkOutput("rst6_iread", 32'(iBeats), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
